// File: rtl/mod_n_counter_pkg.sv
// rtl/mod_n_counter_pkg.sv - shared mode and direction constants for mod_n_counter
package mod_counter_pkg;

    localparam int   CNT_WRAP = 0;
    localparam int   CNT_SAT  = 1;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - parametrised modulo-N up/down counter with load, clear, saturate and compare
module mod_n_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             match,
    output logic             sat
);

    // One extra bit so MODULUS == 2**WIDTH is representable without truncation.
    localparam logic [WIDTH:0] TERM  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO  = '0;
    localparam bit             HOLD  = (SATURATE == CNT_SAT);

    logic [WIDTH:0] cur;
    logic [WIDTH:0] ld_ext;
    logic [WIDTH:0] cmp_ext;
    logic [WIDTH:0] nxt;
    logic           nxt_wrap;
    logic           nxt_sat;
    logic           at_term;

    assign cur     = {1'b0, count};
    assign ld_ext  = {1'b0, load_val};
    assign cmp_ext = {1'b0, cmp_val};
    assign at_term = (up_dn == DIR_UP) ? (cur == TERM) : (cur == ZERO);
    assign tc      = en & at_term;

    always_comb begin
        nxt      = cur;
        nxt_wrap = 1'b0;
        nxt_sat  = 1'b0;
        if (clear) begin
            nxt = ZERO;
        end else if (load) begin
            nxt = (ld_ext < LIMIT) ? ld_ext : TERM;
        end else if (en) begin
            if (!at_term) begin
                nxt = (up_dn == DIR_UP) ? cur + ONE : cur - ONE;
            end else if (HOLD) begin
                nxt_sat = 1'b1;
            end else begin
                nxt      = (up_dn == DIR_UP) ? ZERO : TERM;
                nxt_wrap = 1'b1;
            end
        end
    end

    // match looks at the next count so it lines up with the registered count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
            sat   <= 1'b0;
            match <= 1'b0;
        end else begin
            count <= nxt[WIDTH-1:0];
            wrap  <= nxt_wrap;
            sat   <= nxt_sat;
            match <= (nxt == cmp_ext);
        end
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// tb/tb_mod_n_counter.sv - self-checking bench for mod_n_counter
module tb_mod_n_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] cmp_val = 4'd5;

    logic [3:0] a_count, s_count;
    logic       a_tc, a_wrap, a_match, a_sat;
    logic       s_tc, s_wrap, s_match, s_sat;

    logic       casc_en = 1'b0;
    logic [3:0] c0_count, c1_count;
    logic       c0_tc, c0_wrap, c0_match, c0_sat;
    logic       c1_tc, c1_wrap, c1_match, c1_sat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .cmp_val(cmp_val), .count(a_count), .tc(a_tc),
        .wrap(a_wrap), .match(a_match), .sat(a_sat));

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .cmp_val(cmp_val), .count(s_count), .tc(s_tc),
        .wrap(s_wrap), .match(s_match), .sat(s_sat));

    mod_n_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) casc0 (
        .clk(clk), .reset(reset), .en(casc_en), .up_dn(1'b1), .clear(1'b0), .load(1'b0),
        .load_val(4'd0), .cmp_val(4'd0), .count(c0_count), .tc(c0_tc),
        .wrap(c0_wrap), .match(c0_match), .sat(c0_sat));

    mod_n_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) casc1 (
        .clk(clk), .reset(reset), .en(c0_tc), .up_dn(1'b1), .clear(1'b0), .load(1'b0),
        .load_val(4'd0), .cmp_val(4'd0), .count(c1_count), .tc(c1_tc),
        .wrap(c1_wrap), .match(c1_match), .sat(c1_sat));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    function automatic int f_next(int c, int m, bit s, bit clr, bit ld, int lv, bit e, bit u);
        if (clr) return 0;
        if (ld) return (lv < m) ? lv : m - 1;
        if (!e) return c;
        if (u) return s ? ((c + 1 > m - 1) ? m - 1 : c + 1) : (c + 1) % m;
        return s ? ((c == 0) ? 0 : c - 1) : (c + m - 1) % m;
    endfunction

    function automatic bit f_edge(int c, int m, bit clr, bit ld, bit e, bit u);
        return !clr && !ld && e && (u ? (c == m - 1) : (c == 0));
    endfunction

    int  ma_count = 0, ms_count = 0, n_casc = 0;
    bit  ma_wrap, ma_sat, ma_match, ms_wrap, ms_sat, ms_match;
    bit  model_valid = 1'b0;

    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (!reset) begin
            ma_count <= 0; ma_wrap <= 0; ma_sat <= 0; ma_match <= 0;
            ms_count <= 0; ms_wrap <= 0; ms_sat <= 0; ms_match <= 0;
            n_casc   <= 0;
        end else begin
            ma_count <= f_next(ma_count, 10, 0, clear, load, int'(load_val), en, up_dn);
            ma_wrap  <= f_edge(ma_count, 10, clear, load, en, up_dn);
            ma_sat   <= 1'b0;
            ma_match <= f_next(ma_count, 10, 0, clear, load, int'(load_val), en, up_dn) == int'(cmp_val);
            ms_count <= f_next(ms_count, 10, 1, clear, load, int'(load_val), en, up_dn);
            ms_wrap  <= 1'b0;
            ms_sat   <= f_edge(ms_count, 10, clear, load, en, up_dn);
            ms_match <= f_next(ms_count, 10, 1, clear, load, int'(load_val), en, up_dn) == int'(cmp_val);
            if (casc_en) n_casc <= n_casc + 1;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("a_count", int'(a_count), ma_count);
            chk("a_wrap",  int'(a_wrap),  int'(ma_wrap));
            chk("a_sat",   int'(a_sat),   int'(ma_sat));
            chk("a_match", int'(a_match), int'(ma_match));
            chk("a_tc",    int'(a_tc),    int'(en && (up_dn ? ma_count == 9 : ma_count == 0)));
            chk("s_count", int'(s_count), ms_count);
            chk("s_wrap",  int'(s_wrap),  int'(ms_wrap));
            chk("s_sat",   int'(s_sat),   int'(ms_sat));
            chk("s_match", int'(s_match), int'(ms_match));
            chk("s_tc",    int'(s_tc),    int'(en && (up_dn ? ms_count == 9 : ms_count == 0)));
            chk("casc_x",  int'($isunknown({c1_count, c0_count})), 0);
            chk("casc",    int'({c1_count, c0_count}), n_casc % 256);
            chk("c0_tc",   int'(c0_tc), int'(casc_en && n_casc % 16 == 15));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc();
        cyc();
        chk("lit_reset_count", int'(a_count), 0);
        chk("lit_reset_match", int'(a_match), 0);

        // Up count 0..9,0,1 with match at 5
        reset = 1'b1; en = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("lit_up_count", int'(a_count), k % 10);
            chk("lit_up_wrap", int'(a_wrap), int'(k == 10));
            if (k == 5) chk("lit_up_match", int'(a_match), 1);
            if (k == 9) chk("lit_up_tc", int'(a_tc), 1);
        end

        // Down from 0 wraps to 9; cmp_val=MODULUS never matches
        clear = 1'b1; cyc(); clear = 1'b0;
        up_dn = 1'b0; cmp_val = 4'd10;
        #1 chk("lit_dn_tc", int'(a_tc), 1);
        cyc(); chk("lit_dn_9", int'(a_count), 9); chk("lit_dn_wrap", int'(a_wrap), 1);
        cyc(); chk("lit_dn_8", int'(a_count), 8); chk("lit_dn_wrap0", int'(a_wrap), 0);
        cyc(); chk("lit_dn_7", int'(a_count), 7);
        for (int k = 0; k < 10; k++) cyc();

        // Saturate instance held at 9
        up_dn = 1'b1; load = 1'b1; load_val = 4'd8; cyc(); load = 1'b0;
        cyc(); chk("lit_sat_9a", int'(s_count), 9); chk("lit_sat_0", int'(s_sat), 0);
        cyc(); chk("lit_sat_9b", int'(s_count), 9); chk("lit_sat_1", int'(s_sat), 1);
        chk("lit_sat_tc", int'(s_tc), 1);
        cyc(); chk("lit_sat_nowrap", int'(s_wrap), 0);
        en = 1'b0; cyc(); chk("lit_sat_off", int'(s_sat), 0);

        // Load clamp, clear over load, load over en
        load = 1'b1; load_val = 4'd12; cyc(); chk("lit_ld_clamp", int'(a_count), 9);
        clear = 1'b1; cyc(); clear = 1'b0; chk("lit_ld_clr", int'(a_count), 0);
        en = 1'b1; load_val = 4'd3; cyc(); chk("lit_ld_en", int'(a_count), 3);
        load = 1'b0; load_val = 4'd15; cyc(); cyc();

        // Match at 5, reset mid-count at 7
        cmp_val = 4'd5; clear = 1'b1; cyc(); clear = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk("lit_match", int'(a_match), int'(k == 5));
        end
        reset = 1'b0; cyc();
        chk("lit_rst_count", int'(a_count), 0);
        chk("lit_rst_match", int'(a_match), 0);
        reset = 1'b1; cyc(); chk("lit_after_rst", int'(a_count), 1);

        // Cascade: 300 enabled cycles
        en = 1'b0; reset = 1'b0; cyc(); reset = 1'b1;
        casc_en = 1'b1;
        for (int k = 0; k < 300; k++) cyc();
        casc_en = 1'b0;
        chk("lit_casc_300", int'({c1_count, c0_count}), 44);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
Parametrised modulo-N up/down counter, the successor to the fixed MOD-16 counter. Adds:
- configurable width and modulus
- count enable, direction and synchronous clear
- parallel load
- wrap or saturate mode
- terminal-count output for cascading
- compare-match output

Used as a timebase and event counter. Counters cascade by feeding tc into the next stage's en.

Parameters:
WIDTH, 4, counter width in bits; must satisfy 2**WIDTH >= MODULUS.
MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2**WIDTH.
SATURATE, 0, 0 = wrap at the terminal value; 1 = hold at the terminal value.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
en  input  1  count enable.
up_dn  input  1  direction: 1 = up, 0 = down.
clear  input  1  synchronous clear to 0.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value captured on load.
cmp_val  input  WIDTH  compare value.
count  output  WIDTH  current count (registered).
tc  output  1  terminal count (combinational): en && count is at the terminal value for the current direction.
wrap  output  1  registered one-cycle pulse, asserted the cycle after count wrapped.
match  output  1  registered; high while count == cmp_val.
sat  output  1  registered; high while SATURATE=1 and the counter is held at a terminal value with en=1.

Behaviour:
- Reset (reset=0 at a rising edge):
  - count=0, wrap=0, sat=0.
  - match is recomputed (count 0 vs cmp_val) from the next edge onward; it is 0 during reset.
  - Reset dominates every other input.
- Priority per edge: reset > clear > load > en. Exactly one action per cycle.
- clear=1: count <= 0; wrap <= 0.
- load=1 (clear=0):
  - count <= load_val if load_val < MODULUS, otherwise count <= MODULUS-1 (clamped).
  - No wrap pulse.
- en=1, up_dn=1:
  - If count < MODULUS-1: count <= count+1.
  - At MODULUS-1 with SATURATE=0: count <= 0 and wrap <= 1 for one cycle.
  - At MODULUS-1 with SATURATE=1: count holds and sat <= 1.
- en=1, up_dn=0:
  - If count > 0: count <= count-1.
  - At 0 with SATURATE=0: count <= MODULUS-1 and wrap <= 1.
  - At 0 with SATURATE=1: count holds and sat <= 1.
- en=0: count holds; wrap <= 0; sat <= 0.
- tc is combinational, with zero latency, so a downstream stage advances on the same edge as the wrap.
  - tc = en & (up_dn ? count==MODULUS-1 : count==0).
  - tc is asserted in SATURATE mode as well.
- match <= (next count == cmp_val), so it aligns with count. A cmp_val of MODULUS or above never matches.
- Arithmetic is performed in WIDTH+1 bits internally, so MODULUS=2**WIDTH wraps correctly and no truncation is relied on.
- A direction change mid-count takes effect on the next enabled edge. There is no extra latency.
- Reset or clear mid-count has no residual state: the next enabled edge counts from 0.

Decomposition:
- Package mod_counter_pkg:
  - mode constants CNT_WRAP=0 and CNT_SAT=1
  - direction constants DIR_UP=1 and DIR_DN=0
- No sub-module. Next-state and terminal detection fit in one always block plus the tc assign. The bench cascades two instances.

Test Plan:
1. Reset, then en=1, up_dn=1, MODULUS=10, WIDTH=4 for 12 cycles -> count 0..9,0,1; tc high while count=9; wrap high for exactly one cycle when count=0 after 9.
2. Down count from 0, SATURATE=0, MODULUS=10 -> count 9,8,7; wrap pulse one cycle after the 0->9 transition; tc high while count=0.
3. SATURATE=1, MODULUS=10, up from 8 -> 9, 9, 9; sat high from the second 9 onward; wrap stays 0; en=0 clears sat.
4. load=1, load_val=12, MODULUS=10 -> count=9. Simultaneous clear=1 with load=1 -> count=0. load=1 with en=1 and load_val=3 -> count=3, no increment.
5. cmp_val=5, up count from 0 -> match high in exactly the cycle count=5. Then reset=0 mid-count at count=7 -> count=0 on that edge and match=0.
6. Two instances cascaded (stage0 tc -> stage1 en), both MODULUS=16 and WIDTH=4, 300 cycles -> {stage1,stage0} equals the cycle count mod 256. Also check MODULUS=16 with WIDTH=4: count wraps 15->0 without X.
